ans_encoder: RTL and testbench
==============================

ANS_ENCODER -- requirements
Module: ans_encoder

Interface
REQ-001 Parameter WIDTH, 16: bit width of the signed binary result.
REQ-002 Parameter DIGITS, 4: maximum decimal digits accepted; 10^DIGITS-1 SHALL fit in WIDTH-1 bits.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 key_valid  input  1: key_code presented this cycle.
REQ-006 key_code  input  4: 0x0-0x9 digit, 0xA sign toggle, 0xB backspace, 0xC clear, 0xD enter; 0xE-0xF ignored.
REQ-007 key_ready  output  1: high when a key can be accepted; a key is accepted iff key_valid && key_ready.
REQ-008 sign  output  1: current entry sign, 1 = negative.
REQ-009 num1..num4  output  4 each: BCD echo of the entry, num1 thousands ... num4 units.
REQ-010 count  output  3: digits entered, 0..DIGITS.
REQ-011 value  output  WIDTH: two's-complement result, held until the next result.
REQ-012 value_valid  output  1: one-cycle pulse when value updates.

Function
REQ-013 States: IDLE (count 0), ENTRY (count >= 1 or sign set), CONV (converting), DONE (one cycle).
REQ-014 key_ready SHALL be high in IDLE and ENTRY, low in CONV and DONE; keys offered while low are dropped.
REQ-015 Digit with count < DIGITS: num1<=num2, num2<=num3, num3<=num4, num4<=digit, count+1.
REQ-016 Digit 0 with count 0 SHALL be ignored (no leading zeros); digit with count == DIGITS SHALL be ignored.
REQ-017 Sign toggle SHALL invert sign; count and digits unchanged.
REQ-018 Clear SHALL zero num1..num4, count and sign and go to IDLE; value unchanged.
REQ-019 Enter SHALL go to CONV; acc starts at 0 and for 4 consecutive cycles acc <= acc*10 + num1, num2, num3, num4 in turn.
REQ-020 In DONE, value <= sign ? -acc : acc, value_valid = 1, entry cleared (digits, count, sign) and next state IDLE.
REQ-021 Latency: enter accepted in cycle N -> value_valid high in cycle N+5; key_ready high again in N+6.
REQ-022 Enter with count 0 SHALL produce value 0 regardless of sign (no negative zero).
REQ-023 Codes 0xE/0xF accepted but SHALL change no state.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, num1..num4 = 0, count = 0, sign = 0, acc = 0, value = 0, value_valid = 0; key_ready = 1 after release.
REQ-025 Reset asserted during CONV or DONE SHALL abort conversion with no value_valid pulse.

Configuration
REQ-026 Macro ANS_ENCODER_BACKSPACE_EN defined: backspace with count > 0 SHALL shift num4<=num3, num3<=num2, num2<=num1, num1<=0, count-1; count 0 no effect.
REQ-027 Macro undefined: code 0xB SHALL behave as an ignored code (REQ-023).

Structure
REQ-028 Shared package ans_pkg SHALL hold key code constants, state encoding and DIGITS default, shared with the answer decoder side.
REQ-029 Sub-module mul10_add SHALL compute acc*10 + digit as (acc<<3)+(acc<<1)+digit, purely combinational, WIDTH-bit.

Verification
REQ-030 Keys 1,2,3,4, enter -> value 1234 (0x04D2), value_valid 5 cycles after enter, count back to 0.
REQ-031 Keys sign, 9,9,9,9, enter -> value -9999 (0xD8F1); fifth digit 5 before enter ignored.
REQ-032 Keys 0,0,7, enter -> count 1, num4 = 7, value 7; sign, enter with count 0 -> value 0.
REQ-033 With ANS_ENCODER_BACKSPACE_EN: 3,8,7, backspace, enter -> value 38; without: value 387.
REQ-034 key_valid held high during CONV with digit 5 -> dropped, next entry starts empty; rst_n pulsed mid-CONV -> no value_valid, all outputs 0.
REQ-035 Keys 4,2, clear, 6, enter -> value 6, sign 0.

Source files
------------

// File: rtl/ans_encoder_pkg.sv
//------------------------------------------------------------------------------
// Module : ans_pkg
// Brief  : Key codes, FSM encoding and digit default shared by the answer
//          encoder and decoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ans_pkg;

    localparam int DIGITS_DEFAULT = 4;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ans_encoder_if.sv
//------------------------------------------------------------------------------
// Module : ans_encoder_if
// Brief  : Keypad handshake plus BCD echo and binary result of the encoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ans_encoder_if #(
    parameter int WIDTH = 16
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             key_ready;
    logic             sign;
    logic [3:0]       num1;
    logic [3:0]       num2;
    logic [3:0]       num3;
    logic [3:0]       num4;
    logic [2:0]       count;
    logic [WIDTH-1:0] value;
    logic             value_valid;

    modport master (
        output key_valid, key_code,
        input  key_ready, sign, num1, num2, num3, num4, count, value, value_valid
    );

    modport slave (
        input  key_valid, key_code,
        output key_ready, sign, num1, num2, num3, num4, count, value, value_valid
    );
endinterface

`default_nettype wire

// File: rtl/ans_encoder_mul10_add.sv
//------------------------------------------------------------------------------
// Module : mul10_add
// Brief  : Combinational acc*10 + digit using shift-and-add.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul10_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] result
);
    assign result = (acc << 3) + (acc << 1) + {{(WIDTH-4){1'b0}}, digit};
endmodule

`default_nettype wire

// File: rtl/ans_encoder.sv
//------------------------------------------------------------------------------
// Module : ans_encoder
// Brief  : Keypad BCD entry with sign, converted to a two's-complement value.
//          Optional backspace key enabled by ANS_ENCODER_BACKSPACE_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ans_encoder
    import ans_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    ans_encoder_if.slave bus
);
    localparam logic [2:0] MAX_CNT = 3'(DIGITS);

    state_t           state, next_state;
    logic [3:0]       digs   [4];
    logic [3:0]       n_digs [4];
    logic [2:0]       cnt, n_cnt;
    logic             sgn, n_sgn;
    logic [WIDTH-1:0] acc, n_acc;
    logic [1:0]       step, n_step;
    logic [WIDTH-1:0] value_r, n_value;
    logic             vv_r, n_vv;
    logic [WIDTH-1:0] mac_out;
    logic             ready;
    logic             key_acc;

    mul10_add #(.WIDTH(WIDTH)) u_mac (
        .acc    (acc),
        .digit  (digs[step]),
        .result (mac_out)
    );

    assign ready   = (state == ST_IDLE) || (state == ST_ENTRY);
    assign key_acc = bus.key_valid && ready;

    always_comb begin
        next_state = state;
        n_digs     = digs;
        n_cnt      = cnt;
        n_sgn      = sgn;
        n_acc      = acc;
        n_step     = step;
        n_value    = value_r;
        n_vv       = 1'b0;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (key_acc) begin
                    if (is_digit(bus.key_code)) begin
                        // leading zeros and overflow digits are dropped
                        if (cnt < MAX_CNT && !(bus.key_code == 4'd0 && cnt == 3'd0)) begin
                            n_digs[0] = digs[1];
                            n_digs[1] = digs[2];
                            n_digs[2] = digs[3];
                            n_digs[3] = bus.key_code;
                            n_cnt     = cnt + 3'd1;
                        end
                    end else begin
                        case (bus.key_code)
                            KEY_SIGN:  n_sgn = ~sgn;
                            KEY_CLEAR: begin
                                n_digs = '{default: 4'd0};
                                n_cnt  = 3'd0;
                                n_sgn  = 1'b0;
                            end
`ifdef ANS_ENCODER_BACKSPACE_EN
                            KEY_BKSP: begin
                                if (cnt != 3'd0) begin
                                    n_digs[3] = digs[2];
                                    n_digs[2] = digs[1];
                                    n_digs[1] = digs[0];
                                    n_digs[0] = 4'd0;
                                    n_cnt     = cnt - 3'd1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                    if (bus.key_code == KEY_ENTER) begin
                        next_state = ST_CONV;
                        n_acc      = '0;
                        n_step     = 2'd0;
                    end else begin
                        next_state = (n_cnt != 3'd0 || n_sgn) ? ST_ENTRY : ST_IDLE;
                    end
                end
            end
            ST_CONV: begin
                n_acc  = mac_out;
                n_step = step + 2'd1;
                // result and its strobe land together so both are visible in DONE
                if (step == 2'd3) begin
                    next_state = ST_DONE;
                    n_value    = sgn ? (~mac_out + 1'b1) : mac_out;
                    n_vv       = 1'b1;
                end
            end
            ST_DONE: begin
                n_digs     = '{default: 4'd0};
                n_cnt      = 3'd0;
                n_sgn      = 1'b0;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            digs    <= '{default: 4'd0};
            cnt     <= 3'd0;
            sgn     <= 1'b0;
            acc     <= '0;
            step    <= 2'd0;
            value_r <= '0;
            vv_r    <= 1'b0;
        end else begin
            state   <= next_state;
            digs    <= n_digs;
            cnt     <= n_cnt;
            sgn     <= n_sgn;
            acc     <= n_acc;
            step    <= n_step;
            value_r <= n_value;
            vv_r    <= n_vv;
        end
    end

    assign bus.key_ready   = ready;
    assign bus.sign        = sgn;
    assign bus.num1        = digs[0];
    assign bus.num2        = digs[1];
    assign bus.num3        = digs[2];
    assign bus.num4        = digs[3];
    assign bus.count       = cnt;
    assign bus.value       = value_r;
    assign bus.value_valid = vv_r;
endmodule

`default_nettype wire

// File: tb/tb_ans_encoder.sv
//------------------------------------------------------------------------------
// Module : tb_ans_encoder
// Brief  : Directed keypad sequences with a result scoreboard for ans_encoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ans_encoder;
    localparam logic [3:0] K_SIGN  = 4'hA;
    localparam logic [3:0] K_BKSP  = 4'hB;
    localparam logic [3:0] K_CLEAR = 4'hC;
    localparam logic [3:0] K_ENTER = 4'hD;

    typedef struct {
        logic [15:0] v;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    exp_t sb[$];

    ans_encoder_if #(.WIDTH(16)) bus ();

    ans_encoder #(.WIDTH(16), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every value_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.value_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_value_valid", 32'(bus.value_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("value", 32'(bus.value), 32'(e.v));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic press(input logic [3:0] k);
        int t = 0;
        @(negedge clk);
        while (!bus.key_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.key_ready) chk("key_ready_timeout", 32'd0, 32'd1);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(posedge clk);
        #1;
        last_acc      = cyc;
        bus.key_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] v);
        press(K_ENTER);
        sb.push_back('{v: v, cyc: last_acc + 4});
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk(name, 32'd0, 32'd1);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_value_valid", 32'(bus.value_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_value", 32'(bus.value), 32'd0);
        chk("rst_sign_nums", {27'd0, bus.sign, bus.num1 | bus.num2 | bus.num3 | bus.num4}, 32'd0);

        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        #1 chk("nums_1234", {16'd0, bus.num1, bus.num2, bus.num3, bus.num4}, 32'h1234);
        enter(16'h04D2);
        drain("timeout_1234");
        chk("count_after_1234", 32'(bus.count), 32'd0);
        chk("value_held_1234", 32'(bus.value), 32'h04D2);

        press(K_SIGN); press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd5);
        #1 chk("count_full", 32'(bus.count), 32'd4);
        chk("num4_no_overflow", 32'(bus.num4), 32'd9);
        chk("sign_set", 32'(bus.sign), 32'd1);
        enter(16'hD8F1);
        drain("timeout_9999");
        chk("sign_cleared", 32'(bus.sign), 32'd0);

        press(4'd0); press(4'd0); press(4'd7);
        #1 chk("count_007", 32'(bus.count), 32'd1);
        chk("num4_007", 32'(bus.num4), 32'd7);
        press(4'hE); press(4'hF);
        #1 chk("count_ignored", 32'(bus.count), 32'd1);
        enter(16'd7);
        drain("timeout_007");

        press(K_SIGN);
        enter(16'd0);
        drain("timeout_neg0");

        press(4'd3); press(4'd8); press(4'd7); press(K_BKSP);
`ifdef ANS_ENCODER_BACKSPACE_EN
        #1 chk("count_bksp", 32'(bus.count), 32'd2);
        enter(16'd38);
`else
        #1 chk("count_bksp", 32'(bus.count), 32'd3);
        enter(16'd387);
`endif
        drain("timeout_bksp");

        // a digit held during conversion must be dropped
        press(4'd1);
        enter(16'd1);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd5;
        repeat (5) @(posedge clk);
        #1 bus.key_valid = 1'b0;
        drain("timeout_hold");
        chk("count_after_hold", 32'(bus.count), 32'd0);

        press(4'd2);
        press(K_ENTER);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_conv_value", 32'(bus.value), 32'd0);
        chk("rst_conv_vv", 32'(bus.value_valid), 32'd0);
        chk("rst_conv_count", 32'(bus.count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_conv_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_conv_value_after", 32'(bus.value), 32'd0);

        press(4'd4); press(4'd2); press(K_CLEAR);
        #1 chk("count_clear", 32'(bus.count), 32'd0);
        press(4'd6);
        enter(16'd6);
        drain("timeout_clear");
        chk("sign_clear_seq", 32'(bus.sign), 32'd0);
        chk("value_held_6", 32'(bus.value), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
